// File: rtl/id_ex_fwd_stage.sv
// ---------------------------------------------------------------------------
// id_ex_fwd_stage
// ID/EX pipeline register for the 16-bit pipelined core. It also precomputes
// the EX operand-forwarding selects one cycle early and detects load-use
// hazards. On a hazard it stalls IF/ID and inserts a bubble into EX.
//
// Optional feature: define FWD_STALL_CNT_EN to add the stall_count output.
// This is a saturating 16-bit count of stalled cycles.
// ---------------------------------------------------------------------------
module id_ex_fwd_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              valid_ID,
    input  logic [REG_AW-1:0] r1Addr_ID,
    input  logic [REG_AW-1:0] r2Addr_ID,
    input  logic              r1Use_ID,
    input  logic              r2Use_ID,
    input  logic [DATA_W-1:0] r1Data_ID,
    input  logic [DATA_W-1:0] r2Data_ID,
    input  logic [REG_AW-1:0] rdAddr_ID,
    input  logic              regWrite_ID,
    input  logic              memRead_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic [REG_AW-1:0] rdAddr_EM,
    input  logic              regWrite_EM,
    input  logic [REG_AW-1:0] rdAddr_WB,
    input  logic              regWrite_WB,
    input  logic [DATA_W-1:0] regWriteData,
    output logic              stall,
    output logic              valid_IE,
    output logic [DATA_W-1:0] originalR1Data_IE,
    output logic [DATA_W-1:0] originalR2Data_IE,
    output logic [REG_AW-1:0] rdAddr_IE,
    output logic              regWrite_IE,
    output logic              memRead_IE,
    output logic [CTRL_W-1:0] ctrl_IE,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,   // register operand (possibly WB-bypassed)
        FWD_WB  = 2'b01,   // writeback data
        FWD_EM  = 2'b10    // EX/MEM ALU output
    } fwd_sel_e;

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] r1_data_q,  r1_data_d;
    logic [DATA_W-1:0] r2_data_q,  r2_data_d;
    logic [REG_AW-1:0] rd_addr_q,  rd_addr_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
    fwd_sel_e          fwd_a_q,    fwd_a_d;
    fwd_sel_e          fwd_b_q,    fwd_b_d;

    logic p_ex, p_em, p_wb;
    logic haz, bubble;

    // Select the forwarding source for one operand. EX beats EX/MEM, and
    // EX/MEM beats writeback, because the youngest producer holds the live value.
    function automatic fwd_sel_e pick_fwd(input logic [REG_AW-1:0] addr,
                                          input logic              use_it);
        if (!use_it || addr == '0)              return FWD_REG;
        else if (p_ex && addr == rd_addr_q)     return FWD_EM;
        else if (p_em && addr == rdAddr_EM)     return FWD_WB;
        else                                    return FWD_REG;
    endfunction

    // Choose the operand value latched into EX. Register 0 reads as zero.
    // A writeback happening this cycle bypasses the stale register file read.
    function automatic logic [DATA_W-1:0] pick_data(input logic [REG_AW-1:0] addr,
                                                     input logic              use_it,
                                                     input logic [DATA_W-1:0] rf_data);
        if (addr == '0)
            return '0;
        else if (use_it && !(p_ex && addr == rd_addr_q) &&
                 !(p_em && addr == rdAddr_EM) && p_wb && addr == rdAddr_WB)
            return regWriteData;
        else
            return rf_data;
    endfunction

    // Producer flags, hazard detection and next-state for the ID/EX register.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        p_ex = valid_q & reg_write_q & (rd_addr_q != '0);
        p_em = regWrite_EM & (rdAddr_EM != '0);
        p_wb = regWrite_WB & (rdAddr_WB != '0);

        haz = valid_ID & mem_read_q & p_ex &
              ((r1Use_ID & (r1Addr_ID == rd_addr_q)) |
               (r2Use_ID & (r2Addr_ID == rd_addr_q)));
        bubble = flush | haz | ~valid_ID;

        r1_data_d   = pick_data(r1Addr_ID, r1Use_ID, r1Data_ID);
        r2_data_d   = pick_data(r2Addr_ID, r2Use_ID, r2Data_ID);
        rd_addr_d   = rdAddr_ID;
        valid_d     = 1'b1;
        reg_write_d = regWrite_ID;
        mem_read_d  = memRead_ID;
        ctrl_d      = ctrl_ID;
        fwd_a_d     = pick_fwd(r1Addr_ID, r1Use_ID);
        fwd_b_d     = pick_fwd(r2Addr_ID, r2Use_ID);

        if (bubble) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            ctrl_d      = '0;
            fwd_a_d     = FWD_REG;
            fwd_b_d     = FWD_REG;
        end
    end

    // A flush overrides the hazard: the load-use pair is being squashed anyway.
    assign stall = haz & ~flush;

    // ID/EX pipeline register; reset leaves a bubble in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            r1_data_q   <= '0;
            r2_data_q   <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            ctrl_q      <= '0;
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values.
            valid_q     <= valid_d;
            r1_data_q   <= r1_data_d;
            r2_data_q   <= r2_data_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            ctrl_q      <= ctrl_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
        end
    end

    assign valid_IE          = valid_q;
    assign originalR1Data_IE = r1_data_q;
    assign originalR2Data_IE = r2_data_q;
    assign rdAddr_IE         = rd_addr_q;
    assign regWrite_IE       = reg_write_q;
    assign memRead_IE        = mem_read_q;
    assign ctrl_IE           = ctrl_q;
    assign forward_a         = fwd_a_q;
    assign forward_b         = fwd_b_q;

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Next value of the saturating stall counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_fwd_stage
// Directed bench for id_ex_fwd_stage. The expected values are worked out by
// hand from the pipeline scenario each task builds.
// Define FWD_STALL_CNT_EN to also check stall_count.
// ---------------------------------------------------------------------------
module tb_id_ex_fwd_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_ID;
    logic [3:0]  r1Addr_ID, r2Addr_ID;
    logic        r1Use_ID, r2Use_ID;
    logic [15:0] r1Data_ID, r2Data_ID;
    logic [3:0]  rdAddr_ID;
    logic        regWrite_ID, memRead_ID;
    logic [7:0]  ctrl_ID;
    logic [3:0]  rdAddr_EM;
    logic        regWrite_EM;
    logic [3:0]  rdAddr_WB;
    logic        regWrite_WB;
    logic [15:0] regWriteData;
    logic        stall;
    logic        valid_IE;
    logic [15:0] originalR1Data_IE, originalR2Data_IE;
    logic [3:0]  rdAddr_IE;
    logic        regWrite_IE, memRead_IE;
    logic [7:0]  ctrl_IE;
    logic [1:0]  forward_a, forward_b;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_fwd_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .valid_ID(valid_ID),
        .r1Addr_ID(r1Addr_ID), .r2Addr_ID(r2Addr_ID),
        .r1Use_ID(r1Use_ID), .r2Use_ID(r2Use_ID),
        .r1Data_ID(r1Data_ID), .r2Data_ID(r2Data_ID),
        .rdAddr_ID(rdAddr_ID), .regWrite_ID(regWrite_ID),
        .memRead_ID(memRead_ID), .ctrl_ID(ctrl_ID),
        .rdAddr_EM(rdAddr_EM), .regWrite_EM(regWrite_EM),
        .rdAddr_WB(rdAddr_WB), .regWrite_WB(regWrite_WB),
        .regWriteData(regWriteData), .stall(stall), .valid_IE(valid_IE),
        .originalR1Data_IE(originalR1Data_IE),
        .originalR2Data_IE(originalR2Data_IE),
        .rdAddr_IE(rdAddr_IE), .regWrite_IE(regWrite_IE),
        .memRead_IE(memRead_IE), .ctrl_IE(ctrl_IE),
        .forward_a(forward_a), .forward_b(forward_b)
`ifdef FWD_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    // Advance one rising edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; valid_ID = 0;
        r1Addr_ID = 0; r2Addr_ID = 0; r1Use_ID = 0; r2Use_ID = 0;
        r1Data_ID = 0; r2Data_ID = 0; rdAddr_ID = 0;
        regWrite_ID = 0; memRead_ID = 0; ctrl_ID = 0;
        rdAddr_EM = 0; regWrite_EM = 0; rdAddr_WB = 0; regWrite_WB = 0;
        regWriteData = 0;
    endtask

    // Put a producer instruction in ID so that it sits in EX after the next edge.
    task automatic issue_producer(input logic [3:0] rd, input logic is_load);
        idle_inputs();
        valid_ID = 1; rdAddr_ID = rd; regWrite_ID = 1; memRead_ID = is_load;
        ctrl_ID = 8'h11;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #12;
        total++;
        if ({valid_IE, regWrite_IE, memRead_IE, rdAddr_IE, ctrl_IE,
             forward_a, forward_b, originalR1Data_IE, originalR2Data_IE} !== '0) begin
            bad++;
            $display("FAIL reset_regs: valid=%b ctrl=%h fa=%b fb=%b r1=%h r2=%h want all 0",
                     valid_IE, ctrl_IE, forward_a, forward_b, originalR1Data_IE, originalR2Data_IE);
        end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
`ifdef FWD_STALL_CNT_EN
        total++;
        if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
`endif
        #3 rst_n = 1;
        step();
    endtask

    // ADD R1 in EX; ID reads R1 as source 1 and R4 as source 2.
    task automatic test_fwd_ex();
        issue_producer(4'd1, 1'b0);
        idle_inputs();
        valid_ID = 1; r1Addr_ID = 1; r1Use_ID = 1; r2Addr_ID = 4; r2Use_ID = 1;
        r1Data_ID = 16'hAAAA; r2Data_ID = 16'h4444; rdAddr_ID = 6; regWrite_ID = 1;
        ctrl_ID = 8'h5A;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL ex_stall: got %b want 0", stall); end
        step();
        total++;
        if (forward_a !== 2'b10 || forward_b !== 2'b00) begin
            bad++; $display("FAIL ex_fwd: got fa=%b fb=%b want fa=10 fb=00", forward_a, forward_b);
        end
        total++;
        if (valid_IE !== 1'b1 || rdAddr_IE !== 4'd6 || ctrl_IE !== 8'h5A || originalR2Data_IE !== 16'h4444) begin
            bad++; $display("FAIL ex_capture: got v=%b rd=%0d ctrl=%h r2=%h want v=1 rd=6 ctrl=5a r2=4444",
                            valid_IE, rdAddr_IE, ctrl_IE, originalR2Data_IE);
        end
    endtask

    // Producer of R3 in EX/MEM (EX holds rd=6); ID reads R3 as source 2.
    task automatic test_fwd_em();
        idle_inputs();
        valid_ID = 1; r1Addr_ID = 7; r1Use_ID = 1; r2Addr_ID = 3; r2Use_ID = 1;
        r1Data_ID = 16'h0707; r2Data_ID = 16'h0303; rdAddr_ID = 9; regWrite_ID = 1;
        ctrl_ID = 8'hC3;
        rdAddr_EM = 3; regWrite_EM = 1;
        step();
        total++;
        if (forward_b !== 2'b01 || forward_a !== 2'b00) begin
            bad++; $display("FAIL em_fwd: got fa=%b fb=%b want fa=00 fb=01", forward_a, forward_b);
        end
        total++;
        if (originalR1Data_IE !== 16'h0707 || ctrl_IE !== 8'hC3) begin
            bad++; $display("FAIL em_capture: got r1=%h ctrl=%h want r1=0707 ctrl=c3", originalR1Data_IE, ctrl_IE);
        end
    endtask

    // WB writes R5 = 1234 while the register file still reads 0; R0 reads zero.
    task automatic test_wb_bypass();
        idle_inputs();
        valid_ID = 1; r1Addr_ID = 5; r1Use_ID = 1; r2Addr_ID = 0; r2Use_ID = 1;
        r1Data_ID = 16'h0000; r2Data_ID = 16'hFFFF; rdAddr_ID = 10; regWrite_ID = 1;
        rdAddr_WB = 5; regWrite_WB = 1; regWriteData = 16'h1234;
        step();
        total++;
        if (originalR1Data_IE !== 16'h1234 || forward_a !== 2'b00) begin
            bad++; $display("FAIL wb_bypass: got r1=%h fa=%b want r1=1234 fa=00", originalR1Data_IE, forward_a);
        end
        total++;
        if (originalR2Data_IE !== 16'h0000 || forward_b !== 2'b00) begin
            bad++; $display("FAIL wb_r0: got r2=%h fb=%b want r2=0000 fb=00", originalR2Data_IE, forward_b);
        end
    endtask

    // LW R2 in EX; the ADD uses R2 as source 2. Expect one stall, then forward_b = 01.
    task automatic test_load_use();
        issue_producer(4'd2, 1'b1);
        idle_inputs();
        valid_ID = 1; r1Addr_ID = 8; r1Use_ID = 1; r2Addr_ID = 2; r2Use_ID = 1;
        r1Data_ID = 16'h0808; r2Data_ID = 16'h0202; rdAddr_ID = 11; regWrite_ID = 1;
        ctrl_ID = 8'h77;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", stall); end
        step();
        total++;
        if (valid_IE !== 1'b0 || regWrite_IE !== 1'b0 || ctrl_IE !== 8'h00 || forward_b !== 2'b00) begin
            bad++; $display("FAIL lu_bubble: got v=%b we=%b ctrl=%h fb=%b want v=0 we=0 ctrl=00 fb=00",
                            valid_IE, regWrite_IE, ctrl_IE, forward_b);
        end
        // The load has moved on to EX/MEM; ID still holds the same ADD.
        rdAddr_EM = 2; regWrite_EM = 1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once: got %b want 0", stall); end
        step();
        total++;
        if (valid_IE !== 1'b1 || forward_b !== 2'b01 || forward_a !== 2'b00 || rdAddr_IE !== 4'd11) begin
            bad++; $display("FAIL lu_reissue: got v=%b fa=%b fb=%b rd=%0d want v=1 fa=00 fb=01 rd=11",
                            valid_IE, forward_a, forward_b, rdAddr_IE);
        end
`ifdef FWD_STALL_CNT_EN
        total++;
        if (stall_count !== 16'd1) begin bad++; $display("FAIL lu_count: got %0d want 1", stall_count); end
`endif
    endtask

    // A flush coincides with a load-use hazard; then check a producer whose destination is R0.
    task automatic test_flush_and_r0();
        issue_producer(4'd2, 1'b1);
        idle_inputs();
        valid_ID = 1; r1Addr_ID = 2; r1Use_ID = 1; rdAddr_ID = 12; regWrite_ID = 1;
        ctrl_ID = 8'h99; flush = 1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall); end
        step();
        total++;
        if (valid_IE !== 1'b0 || ctrl_IE !== 8'h00) begin
            bad++; $display("FAIL flush_bubble: got v=%b ctrl=%h want v=0 ctrl=00", valid_IE, ctrl_IE);
        end
        issue_producer(4'd0, 1'b1);
        idle_inputs();
        valid_ID = 1; r1Addr_ID = 0; r1Use_ID = 1; r2Addr_ID = 0; r2Use_ID = 1;
        r1Data_ID = 16'hBEEF; r2Data_ID = 16'hCAFE; rdAddr_ID = 13; regWrite_ID = 1;
        rdAddr_EM = 0; regWrite_EM = 1; rdAddr_WB = 0; regWrite_WB = 1; regWriteData = 16'h5555;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall: got %b want 0", stall); end
        step();
        total++;
        if (forward_a !== 2'b00 || forward_b !== 2'b00 ||
            originalR1Data_IE !== 16'h0000 || originalR2Data_IE !== 16'h0000 || valid_IE !== 1'b1) begin
            bad++; $display("FAIL r0_fwd: got fa=%b fb=%b r1=%h r2=%h v=%b want 00 00 0000 0000 1",
                            forward_a, forward_b, originalR1Data_IE, originalR2Data_IE, valid_IE);
        end
    endtask

    // Assert reset asynchronously while stalled, then make one normal capture.
    task automatic test_reset_mid_stall();
        issue_producer(4'd4, 1'b1);
        idle_inputs();
        valid_ID = 1; r1Addr_ID = 4; r1Use_ID = 1; r2Addr_ID = 4; r2Use_ID = 1;
        rdAddr_ID = 14; regWrite_ID = 1;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall: got %b want 1", stall); end
        #2 rst_n = 0;
        #1;
        total++;
        if (stall !== 1'b0 || valid_IE !== 1'b0 || memRead_IE !== 1'b0 || rdAddr_IE !== 4'd0 ||
            regWrite_IE !== 1'b0 || ctrl_IE !== 8'h00 || forward_a !== 2'b00 || forward_b !== 2'b00) begin
            bad++; $display("FAIL rst_async: got st=%b v=%b mr=%b rd=%0d we=%b ctrl=%h want all 0",
                            stall, valid_IE, memRead_IE, rdAddr_IE, regWrite_IE, ctrl_IE);
        end
        step();
        rst_n = 1;
        idle_inputs();
        valid_ID = 1; r1Addr_ID = 9; r1Use_ID = 1; r2Addr_ID = 10; r2Use_ID = 1;
        r1Data_ID = 16'h1111; r2Data_ID = 16'h2222; rdAddr_ID = 15; regWrite_ID = 1;
        memRead_ID = 1; ctrl_ID = 8'hE1;
        step();
        total++;
        if (valid_IE !== 1'b1 || rdAddr_IE !== 4'd15 || memRead_IE !== 1'b1 || ctrl_IE !== 8'hE1 ||
            originalR1Data_IE !== 16'h1111 || originalR2Data_IE !== 16'h2222 ||
            forward_a !== 2'b00 || forward_b !== 2'b00) begin
            bad++; $display("FAIL rst_recover: got v=%b rd=%0d mr=%b ctrl=%h r1=%h r2=%h want 1 15 1 e1 1111 2222",
                            valid_IE, rdAddr_IE, memRead_IE, ctrl_IE, originalR1Data_IE, originalR2Data_IE);
        end
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_em();
        test_wb_bypass();
        test_load_use();
        test_flush_and_r0();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
